interval_capture_counter: RTL
=============================

// Module: interval_capture_counter
// PURPOSE
//   Measuring end of the timer scheme: counts clock cycles between a Start and a Stop event
//   and presents the captured interval through a Valid/Ack handshake.
//   Sits beside the preset/zero down-counters in the counter cell library; used for sensor
//   response-time and pulse-width measurement in the WSN SoC.
// PARAMETERS
//   Width   16   counter and result width in bits; result saturates at 2**Width-1
// PORTS
//   Reset_n_i     in   1      asynchronous reset, active low
//   Clk_i         in   1      single clock, all state on rising edge
//   Enable_i      in   1      arms the block; low aborts a running measurement
//   Start_i       in   1      start event, sampled on clock edge (level, single-cycle pulse expected)
//   Stop_i        in   1      stop event, sampled on clock edge
//   Ack_i         in   1      consumer acknowledges captured result
//   Value_o       out  Width  captured interval in clock cycles
//   Valid_o       out  1      Value_o/Overflow_o hold a fresh unacknowledged result
//   Overflow_o    out  1      captured interval saturated
//   Busy_o        out  1      measurement running (state COUNT)
// BEHAVIOUR
//   Reset (async, Reset_n_i=0): state IDLE, internal count 0, Value_o=0, Valid_o=0,
//     Overflow_o=0, Busy_o=0. Reset mid-COUNT or mid-DONE discards everything.
//   FSM: IDLE -> COUNT -> DONE -> IDLE.
//   IDLE: Start_i & Enable_i at edge t0 -> COUNT, count<=0. Stop_i ignored in IDLE.
//   COUNT: Busy_o=1. Each edge without Stop: count<=count+1, saturating at 2**Width-1.
//     Stop_i at edge t1 -> DONE; Value_o<=min(t1-t0, 2**Width-1) (i.e. count+1 saturated);
//     Overflow_o<=1 iff saturation occurred; Valid_o<=1 at same edge.
//     Start_i in COUNT ignored (no restart); Start_i & Stop_i together: Stop wins.
//     Enable_i=0 in COUNT (priority over Stop_i) -> IDLE, no capture, Value_o/Overflow_o unchanged.
//   DONE: Valid_o=1, Value_o/Overflow_o stable. Ack_i -> IDLE, Valid_o=0 next cycle.
//     Start_i ignored in DONE, including the Ack cycle; new Start earliest one cycle after Ack.
//     Enable_i has no effect in DONE (result kept until Ack).
//   Value_o/Overflow_o retain last capture after Ack until the next capture.
//   Minimum interval: Stop one cycle after Start -> Value_o=1. Outputs are registered.
// CONFIGURATION
//   INTERVAL_CAPTURE_TIMEOUT_EN defined: extra port TimeoutVal_i in Width and output
//     Timeout_o out 1 (reset 0). In COUNT, if TimeoutVal_i!=0 and count+1==TimeoutVal_i
//     without Stop_i: -> DONE, Value_o=TimeoutVal_i, Timeout_o=1, Valid_o=1. Stop_i at that
//     same edge is a normal capture (Timeout_o=0). Timeout_o cleared on Ack/next capture.
//     TimeoutVal_i=0 disables timeout.
//   Not defined: no such ports; measurement only ends on Stop_i or Enable_i abort.
// STRUCTURE
//   Shared package counter_pkg: FSM state encoding (IDLE=2'd0, COUNT=2'd1, DONE=2'd2),
//     saturating-max constant function of Width.
//   One sub-module: sat_up_counter (clear, enable, Width param, saturated flag out);
//     FSM, capture registers and handshake stay in this module.
// TESTING
//   Start at t0, Stop at t0+5 -> Valid_o=1 from t0+5 edge, Value_o=5, Overflow_o=0, Busy_o=0.
//   Width=4, Stop 20 cycles after Start -> Value_o=15, Overflow_o=1; Ack -> Valid_o=0 next cycle.
//   Start pulse at t0+2 during COUNT, then Start&Stop together at t0+7 -> Value_o=7.
//   Enable_i drops at t0+3 -> Busy_o=0 next cycle, Valid_o stays 0, Value_o unchanged.
//   Reset_n_i low during COUNT and during DONE -> all outputs 0 immediately; Start re-arms.
//   TIMEOUT_EN, TimeoutVal_i=8, no Stop -> Valid_o=1, Value_o=8, Timeout_o=1 at t0+8.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared definitions for the counter cell library: FSM state encoding and saturation limit.
package counter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_DONE  = 2'd2
  } cap_state_e;

  // All-ones value of a w-bit counter; the 32-bit shift wrap yields the right value for w=32.
  function automatic int unsigned sat_max(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/sat_up_counter.sv
// Saturating up-counter with synchronous clear and a registered saturation flag.
module sat_up_counter
  import counter_pkg::*;
#(
  parameter int unsigned Width = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [Width-1:0] count_o,
  output logic             sat_o
);

  localparam logic [Width-1:0] MaxVal = Width'(sat_max(Width));

  logic [Width-1:0] count_q, count_d;
  logic             sat_q, sat_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i && !sat_q) begin
      count_d = count_q + Width'(1);
    end
    sat_d = (count_d == MaxVal);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      count_q <= '0;
      sat_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      sat_q   <= sat_d;
    end
  end

  assign count_o = count_q;
  assign sat_o   = sat_q;

endmodule

// File: rtl/interval_capture_counter.sv
// Start/Stop interval measurement with Valid/Ack result handshake.
// Optional timeout (port TimeoutVal_i, flag Timeout_o) enabled by INTERVAL_CAPTURE_TIMEOUT_EN.
module interval_capture_counter
  import counter_pkg::*;
#(
  parameter int unsigned Width = 16
) (
  input  logic             Reset_n_i,
  input  logic             Clk_i,
  input  logic             Enable_i,
  input  logic             Start_i,
  input  logic             Stop_i,
  input  logic             Ack_i,
`ifdef INTERVAL_CAPTURE_TIMEOUT_EN
  input  logic [Width-1:0] TimeoutVal_i,
  output logic             Timeout_o,
`endif
  output logic [Width-1:0] Value_o,
  output logic             Valid_o,
  output logic             Overflow_o,
  output logic             Busy_o
);

  localparam logic [Width-1:0] MaxVal = Width'(sat_max(Width));

  cap_state_e       state_q, state_d;
  logic [Width-1:0] value_q, value_d;
  logic             valid_q, valid_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;
  logic             cnt_clr, cnt_en;
  logic [Width-1:0] cnt;
  logic             cnt_sat;
  logic             timeout_hit;

  sat_up_counter #(.Width(Width)) u_cnt (
    .clk_i   (Clk_i),
    .rst_n_i (Reset_n_i),
    .clr_i   (cnt_clr),
    .en_i    (cnt_en),
    .count_o (cnt),
    .sat_o   (cnt_sat)
  );

`ifdef INTERVAL_CAPTURE_TIMEOUT_EN
  logic timeout_q, timeout_d;
  logic [Width:0] cnt_inc_wide;

  // Wide compare so a saturated count can never alias onto the programmed limit.
  assign cnt_inc_wide = {1'b0, cnt} + (Width+1)'(1);
  assign timeout_hit  = (TimeoutVal_i != '0) && (cnt_inc_wide == {1'b0, TimeoutVal_i});
`else
  assign timeout_hit  = 1'b0;
`endif

  always_ff @(posedge Clk_i or negedge Reset_n_i) begin
    if (!Reset_n_i) state_q <= ST_IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (Start_i && Enable_i) state_d = ST_COUNT;
      ST_COUNT: begin
        if (!Enable_i)                  state_d = ST_IDLE;
        else if (Stop_i || timeout_hit) state_d = ST_DONE;
      end
      ST_DONE:  if (Ack_i) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Capture / handshake next values; abort leaves the previous result untouched.
  always_comb begin
    value_d = value_q;
    ovf_d   = ovf_q;
    valid_d = valid_q;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
`ifdef INTERVAL_CAPTURE_TIMEOUT_EN
    timeout_d = timeout_q;
`endif
    unique case (state_q)
      ST_IDLE:  cnt_clr = Start_i && Enable_i;
      ST_COUNT: begin
        if (Enable_i) begin
          if (Stop_i) begin
            value_d = cnt_sat ? MaxVal : cnt + Width'(1);
            ovf_d   = cnt_sat;
            valid_d = 1'b1;
`ifdef INTERVAL_CAPTURE_TIMEOUT_EN
            timeout_d = 1'b0;
          end else if (timeout_hit) begin
            value_d   = TimeoutVal_i;
            ovf_d     = 1'b0;
            valid_d   = 1'b1;
            timeout_d = 1'b1;
`endif
          end else begin
            cnt_en = 1'b1;
          end
        end
      end
      ST_DONE: begin
        if (Ack_i) begin
          valid_d = 1'b0;
`ifdef INTERVAL_CAPTURE_TIMEOUT_EN
          timeout_d = 1'b0;
`endif
        end
      end
      default: valid_d = 1'b0;
    endcase
    busy_d = (state_d == ST_COUNT);
  end

  always_ff @(posedge Clk_i or negedge Reset_n_i) begin
    if (!Reset_n_i) begin
      value_q <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
`ifdef INTERVAL_CAPTURE_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
    end else begin
      value_q <= value_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
`ifdef INTERVAL_CAPTURE_TIMEOUT_EN
      timeout_q <= timeout_d;
`endif
    end
  end

  assign Value_o    = value_q;
  assign Valid_o    = valid_q;
  assign Overflow_o = ovf_q;
  assign Busy_o     = busy_q;
`ifdef INTERVAL_CAPTURE_TIMEOUT_EN
  assign Timeout_o  = timeout_q;
`endif

endmodule
